exc_ctrl: RTL and testbench



---
 rtl/exc_ctrl.sv | 127 ++++++++++++
 tb/tb_exc_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/ertn sequencer: prioritises WB exception sources, pulses the CSR commit, redirects fetch, then drains.
// Latency: COMMIT one cycle after trigger, redirect_valid two cycles after; holds redirect until redirect_ready, then FLUSH_CYCLES drain cycles.
module exc_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc_in,
    input  logic        wb_exc_adef,
    input  logic        wb_exc_ine,
    input  logic        wb_exc_sys,
    input  logic        wb_exc_brk,
    input  logic        wb_exc_ale,
    input  logic        wb_ertn,
    input  logic        int_pending,
    output logic        wb_allow,
    output logic        pipe_flush,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    input  logic [31:0] csr_ex_entry,
    input  logic [31:0] csr_ex_epc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_REDIRECT,
        S_DRAIN
    } state_e;

    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic        ertn_q, ertn_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rpc_q, rpc_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        any_exc;
    logic        trigger;
    logic [5:0]  ecode_sel;

    assign any_exc = int_pending | wb_exc_adef | wb_exc_ine | wb_exc_sys | wb_exc_brk | wb_exc_ale;
    assign trigger = wb_valid & (any_exc | wb_ertn);

    always_comb begin
        ecode_sel = 6'h00;
        if (int_pending)      ecode_sel = 6'h00;
        else if (wb_exc_adef) ecode_sel = 6'h08;
        else if (wb_exc_ine)  ecode_sel = 6'h0D;
        else if (wb_exc_sys)  ecode_sel = 6'h0B;
        else if (wb_exc_brk)  ecode_sel = 6'h0C;
        else if (wb_exc_ale)  ecode_sel = 6'h09;
    end

    always_comb begin
        state_d = state_q;
        ertn_d  = ertn_q;
        ecode_d = ecode_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    // Any exception source wins over a simultaneous ertn.
                    state_d = S_COMMIT;
                    ertn_d  = ~any_exc;
                    ecode_d = any_exc ? ecode_sel : 6'h00;
                    pc_d    = wb_pc_in;
                end
            end
            S_COMMIT: begin
                state_d = S_REDIRECT;
                rpc_d   = ertn_q ? csr_ex_epc : csr_ex_entry;
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ertn_q  <= 1'b0;
            ecode_q <= 6'h00;
            pc_q    <= 32'h0;
            rpc_q   <= 32'h0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ertn_q  <= ertn_d;
            ecode_q <= ecode_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_allow       = (state_q == S_IDLE);
    assign pipe_flush     = (state_q != S_IDLE);
    assign wb_ex          = (state_q == S_COMMIT) & ~ertn_q;
    assign ertn_flush     = (state_q == S_COMMIT) & ertn_q;
    assign wb_ecode       = ecode_q;
    assign wb_esubcode    = 9'h000;
    assign wb_pc          = pc_q;
    assign redirect_valid = (state_q == S_REDIRECT);
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed vector table, stall/reset sequences, and random traffic against a timestamp model.
module tb_exc_ctrl;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc_in;
    logic        wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale;
    logic        wb_ertn, int_pending;
    logic        wb_allow, pipe_flush, wb_ex, ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] csr_ex_entry, csr_ex_epc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    always #5 clk = ~clk;

    exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc_in(wb_pc_in),
        .wb_exc_adef(wb_exc_adef), .wb_exc_ine(wb_exc_ine), .wb_exc_sys(wb_exc_sys),
        .wb_exc_brk(wb_exc_brk), .wb_exc_ale(wb_exc_ale), .wb_ertn(wb_ertn),
        .int_pending(int_pending), .wb_allow(wb_allow), .pipe_flush(pipe_flush),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .csr_ex_entry(csr_ex_entry),
        .csr_ex_epc(csr_ex_epc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one outstanding event described by timestamps.
    bit          m_active = 1'b0;
    int          t_trig = 0;
    int          t_acc = -1;
    bit          m_ertn = 1'b0;
    logic [5:0]  m_ecode = 6'h0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_rpc = 32'h0;

    bit          seen_commit;
    logic        seen_ex, seen_ertn;
    logic [5:0]  seen_ecode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] prio_code(input logic [5:0] srcs);
        // srcs ordered highest priority first: int, adef, ine, sys, brk, ale
        logic [5:0] codes [6];
        codes = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        for (int k = 0; k < 6; k++)
            if (srcs[5-k]) return codes[k];
        return 6'h00;
    endfunction

    task automatic clear_inputs();
        wb_valid = 0; wb_exc_adef = 0; wb_exc_ine = 0; wb_exc_sys = 0;
        wb_exc_brk = 0; wb_exc_ale = 0; wb_ertn = 0; int_pending = 0;
    endtask

    // Inputs for this cycle are already applied; check outputs, advance model, move to next negedge.
    task automatic tick();
        bit busy, commit, redir;
        logic [5:0] srcs;
        if (m_active && t_acc >= 0 && cyc > t_acc + FC) m_active = 0;
        busy   = m_active && cyc > t_trig;
        commit = m_active && cyc == t_trig + 1;
        redir  = m_active && cyc >= t_trig + 2 && t_acc < 0;

        chk("wb_allow", wb_allow, !busy);
        chk("pipe_flush", pipe_flush, busy);
        chk("wb_ex", wb_ex, commit && !m_ertn);
        chk("ertn_flush", ertn_flush, commit && m_ertn);
        chk("redirect_valid", redirect_valid, redir);
        chk("wb_esubcode", wb_esubcode, 0);
        if (commit) begin
            chk("wb_ecode", wb_ecode, m_ertn ? 6'h00 : m_ecode);
            chk("wb_pc", wb_pc, m_pc);
            seen_commit = 1; seen_ex = wb_ex; seen_ertn = ertn_flush; seen_ecode = wb_ecode;
        end
        if (redir) chk("redirect_pc", redirect_pc, m_rpc);

        if (reset) begin
            m_active = 0;
        end else begin
            srcs = {int_pending, wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale};
            if (!busy && wb_valid && (srcs != 0 || wb_ertn)) begin
                m_active = 1; t_trig = cyc; t_acc = -1;
                m_ertn = (srcs == 0);
                m_ecode = prio_code(srcs);
                m_pc = wb_pc_in;
            end
            if (commit) m_rpc = m_ertn ? csr_ex_epc : csr_ex_entry;
            if (redir && redirect_ready) t_acc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    typedef struct {
        logic       adef, ine, sys, brk, ale, ertn, intp;
        logic       exp_ex;
        logic [5:0] exp_ecode;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{0,0,1,0,0,0,0, 1, 6'h0B};  // SYS
        tbl[1] = '{0,0,0,0,0,1,0, 0, 6'h00};  // ertn
        tbl[2] = '{1,1,0,0,1,0,1, 1, 6'h00};  // ADEF+INE+ALE+INT
        tbl[3] = '{1,1,0,0,1,0,0, 1, 6'h08};  // ADEF+INE+ALE
        tbl[4] = '{0,0,0,1,0,1,0, 1, 6'h0C};  // BRK beats ertn
        tbl[5] = '{0,1,1,1,1,0,0, 1, 6'h0D};  // INE over SYS/BRK/ALE
        tbl[6] = '{0,0,0,0,1,0,0, 1, 6'h09};  // ALE alone
        tbl[7] = '{0,0,1,1,0,0,0, 1, 6'h0B};  // SYS over BRK
        tbl[8] = '{0,0,0,0,0,1,1, 1, 6'h00};  // INT beats ertn

        reset = 1; clear_inputs();
        wb_pc_in = 0; csr_ex_entry = 0; csr_ex_epc = 0; redirect_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_wb_allow", wb_allow, 1);
        chk("rst_pipe_flush", pipe_flush, 0);
        chk("rst_wb_ex", wb_ex, 0);
        chk("rst_ertn_flush", ertn_flush, 0);
        chk("rst_wb_ecode", wb_ecode, 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        tick();
        reset = 0;

        // Directed vectors, ready held high.
        for (int i = 0; i < 9; i++) begin
            wb_pc_in = 32'h1C000100 + 32'(i * 4);
            csr_ex_entry = 32'h1C008000; csr_ex_epc = 32'h1C000104; redirect_ready = 1;
            wb_valid = 1; wb_exc_adef = tbl[i].adef; wb_exc_ine = tbl[i].ine;
            wb_exc_sys = tbl[i].sys; wb_exc_brk = tbl[i].brk; wb_exc_ale = tbl[i].ale;
            wb_ertn = tbl[i].ertn; int_pending = tbl[i].intp;
            seen_commit = 0;
            tick();
            clear_inputs();
            for (int k = 0; k < 3 + FC; k++) begin
                if (k == 2) chk("tbl_redirect_pc", redirect_pc, tbl[i].exp_ex ? 32'h1C008000 : 32'h1C000104);
                tick();
            end
            chk("tbl_idle", wb_allow, 1);
            chk("tbl_commit_seen", seen_commit, 1);
            chk("tbl_wb_ex", seen_ex, tbl[i].exp_ex);
            chk("tbl_ertn_flush", seen_ertn, !tbl[i].exp_ex);
            if (tbl[i].exp_ex) chk("tbl_ecode", seen_ecode, tbl[i].exp_ecode);
        end

        // int_pending without wb_valid must not trigger.
        int_pending = 1; wb_exc_sys = 1;
        repeat (3) tick();
        chk("no_valid_idle", wb_allow, 1);
        clear_inputs();

        // Redirect stall: ready low 5 cycles while CSR inputs wander.
        wb_valid = 1; wb_exc_sys = 1; wb_pc_in = 32'h1C000200;
        csr_ex_entry = 32'h1C009000; redirect_ready = 0;
        tick(); clear_inputs();
        tick();
        for (int k = 0; k < 5; k++) begin
            csr_ex_entry = $urandom; csr_ex_epc = $urandom;
            wb_valid = 1; wb_ertn = 1;
            chk("stall_redirect_pc", redirect_pc, 32'h1C009000);
            tick();
        end
        clear_inputs(); redirect_ready = 1;
        tick();
        redirect_ready = 0;
        repeat (FC) tick();
        chk("stall_idle", wb_allow, 1);

        // Reset while in REDIRECT, then a normal SYS.
        wb_valid = 1; wb_exc_sys = 1; wb_pc_in = 32'h1C000300;
        tick(); clear_inputs();
        tick();
        chk("pre_rst_redirect", redirect_valid, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("post_rst_allow", wb_allow, 1);
        chk("post_rst_flush", pipe_flush, 0);
        chk("post_rst_redirect", redirect_valid, 0);
        wb_valid = 1; wb_exc_sys = 1; wb_pc_in = 32'h1C000400; redirect_ready = 1;
        seen_commit = 0;
        tick(); clear_inputs();
        repeat (3 + FC) tick();
        chk("post_rst_commit", seen_commit, 1);
        chk("post_rst_ecode", seen_ecode, 6'h0B);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            wb_valid       = ($urandom_range(0, 3) == 0);
            wb_pc_in       = $urandom;
            wb_exc_adef    = ($urandom_range(0, 7) == 0);
            wb_exc_ine     = ($urandom_range(0, 7) == 0);
            wb_exc_sys     = ($urandom_range(0, 7) == 0);
            wb_exc_brk     = ($urandom_range(0, 7) == 0);
            wb_exc_ale     = ($urandom_range(0, 7) == 0);
            wb_ertn        = ($urandom_range(0, 5) == 0);
            int_pending    = ($urandom_range(0, 7) == 0);
            csr_ex_entry   = $urandom;
            csr_ex_epc     = $urandom;
            redirect_ready = ($urandom_range(0, 1) == 0);
            reset          = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
